// File: rtl/decode_dispatch_ctrl.sv
// In-order decode/dispatch front end: a small instruction FIFO feeding a single registered
// dispatch slot that is steered to the ALU or LSU reservation station over valid/ready.
module decode_dispatch_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             lsu_valid,
  input  logic             lsu_ready,
  output logic [31:0]      uop_pc,
  output logic [4:0]       uop_rd,
  output logic [4:0]       uop_rs1,
  output logic [4:0]       uop_rs2,
  output logic [31:0]      uop_imm,
  output logic             uop_use_imm,
  output logic [3:0]       uop_alu_op,
  output logic             uop_is_store,
  output logic             illegal_instr,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu_op;
    logic        is_store;
    logic        is_lsu;
  } uop_t;

  logic [31:0]    instr_mem_q [DEPTH];
  logic [31:0]    pc_mem_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             slot_valid_q, slot_valid_d;
  uop_t             uop_q, uop_d;
  logic             illegal_q, illegal_d;

  logic        push, pop, load, fire, slot_free, not_empty, head_legal;
  logic [31:0] head_instr, head_pc;
  logic [2:0]  head_f3;
  uop_t        dec;

  assign fetch_ready = (count_q != (PTR_W+1)'(DEPTH));
  assign not_empty   = (count_q != '0);
  assign push        = fetch_valid & fetch_ready & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= fetch_instr;
      pc_mem_q[wr_ptr_q]    <= fetch_pc;
    end
  end

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_pc    = pc_mem_q[rd_ptr_q];
  assign head_f3    = head_instr[14:12];

  // Decode of the FIFO head; fields not defined by the format stay zero.
  always_comb begin
    dec        = '0;
    head_legal = 1'b1;
    dec.pc     = head_pc;
    case (head_instr[6:0])
      OPC_R: begin
        dec.rd     = head_instr[11:7];
        dec.rs1    = head_instr[19:15];
        dec.rs2    = head_instr[24:20];
        dec.alu_op = {head_instr[30], head_f3};
      end
      OPC_I: begin
        dec.rd      = head_instr[11:7];
        dec.rs1     = head_instr[19:15];
        dec.imm     = {{20{head_instr[31]}}, head_instr[31:20]};
        dec.use_imm = 1'b1;
        dec.alu_op  = {1'b0, head_f3};
      end
      OPC_LW: begin
        dec.rd      = head_instr[11:7];
        dec.rs1     = head_instr[19:15];
        dec.imm     = {{20{head_instr[31]}}, head_instr[31:20]};
        dec.use_imm = 1'b1;
        dec.is_lsu  = 1'b1;
      end
      OPC_SW: begin
        dec.rs1      = head_instr[19:15];
        dec.rs2      = head_instr[24:20];
        dec.imm      = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        dec.use_imm  = 1'b1;
        dec.is_store = 1'b1;
        dec.is_lsu   = 1'b1;
      end
      OPC_LUI: begin
        dec.rd      = head_instr[11:7];
        dec.imm     = {head_instr[31:12], 12'b0};
        dec.use_imm = 1'b1;
      end
      default: head_legal = 1'b0;
    endcase
  end

  assign fire      = slot_valid_q & (uop_q.is_lsu ? lsu_ready : alu_ready);
  assign slot_free = ~slot_valid_q | fire;
  // Illegal heads are discarded even while the slot is stalled.
  assign pop       = not_empty & (~head_legal | slot_free);
  assign load      = not_empty & head_legal & slot_free;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d     = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
    count_d      = count_q + (push ? (PTR_W+1)'(1) : '0) - (pop ? (PTR_W+1)'(1) : '0);
    slot_valid_d = slot_valid_q;
    uop_d        = uop_q;
    illegal_d    = not_empty & ~head_legal;
    if (fire) begin
      slot_valid_d = 1'b0;
    end
    if (load) begin
      slot_valid_d = 1'b1;
      uop_d        = dec;
    end
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      slot_valid_d = 1'b0;
      illegal_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      slot_valid_q <= 1'b0;
      uop_q        <= '0;
      illegal_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      slot_valid_q <= slot_valid_d;
      uop_q        <= uop_d;
      illegal_q    <= illegal_d;
    end
  end

  assign alu_valid     = slot_valid_q & ~uop_q.is_lsu;
  assign lsu_valid     = slot_valid_q & uop_q.is_lsu;
  assign uop_pc        = uop_q.pc;
  assign uop_rd        = uop_q.rd;
  assign uop_rs1       = uop_q.rs1;
  assign uop_rs2       = uop_q.rs2;
  assign uop_imm       = uop_q.imm;
  assign uop_use_imm   = uop_q.use_imm;
  assign uop_alu_op    = uop_q.alu_op;
  assign uop_is_store  = uop_q.is_store;
  assign illegal_instr = illegal_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Bench for decode_dispatch_ctrl: a decode vector table checked through a fire-order
// scoreboard, plus hand sequences for stalls, fill/wrap, illegal drop, flush and reset.
module tb_decode_dispatch_ctrl;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic fetch_valid = 1'b0;
  logic [31:0] fetch_instr = '0;
  logic [31:0] fetch_pc = '0;
  logic alu_ready = 1'b0;
  logic lsu_ready = 1'b0;
  logic fetch_ready, alu_valid, lsu_valid, uop_use_imm, uop_is_store, illegal_instr;
  logic [31:0] uop_pc, uop_imm;
  logic [4:0] uop_rd, uop_rs1, uop_rs2;
  logic [3:0] uop_alu_op;
  logic [PTR_W:0] fifo_count;

  decode_dispatch_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .uop_pc(uop_pc), .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
    .uop_imm(uop_imm), .uop_use_imm(uop_use_imm), .uop_alu_op(uop_alu_op),
    .uop_is_store(uop_is_store), .illegal_instr(illegal_instr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_lsu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu_op;
    logic        is_store;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[8];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input logic is_lsu, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm,
                               input logic use_imm, input logic [3:0] alu_op,
                               input logic is_store);
    vec_t v;
    v.instr = instr; v.pc = pc; v.is_lsu = is_lsu; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.use_imm = use_imm; v.alu_op = alu_op; v.is_store = is_store;
    return v;
  endfunction

  // ADDI xk, x0, k
  function automatic vec_t mk_addi(input int k, input logic [31:0] pc);
    return mkv({12'(k), 5'd0, 3'd0, 5'(k), 7'h13}, pc, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k),
               1'b1, 4'h0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_v(input vec_t v, input bit to_sb);
    fetch_valid = 1'b1;
    fetch_instr = v.instr;
    fetch_pc    = v.pc;
    if (to_sb) sb.push_back(v);
    tick();
    fetch_valid = 1'b0;
  endtask

  // Scoreboard: every accepted handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    vec_t e;
    logic [86:0] got, exp;
    if (rst_n && !flush && ((alu_valid && alu_ready) || (lsu_valid && lsu_ready))) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL fire_unexpected: pc=0x%08h alu_valid=%0b lsu_valid=%0b, none expected",
                 uop_pc, alu_valid, lsu_valid);
      end else begin
        e = sb.pop_front();
        got = {lsu_valid, alu_valid, uop_pc, uop_rd, uop_rs1, uop_rs2, uop_imm, uop_use_imm,
               uop_alu_op, uop_is_store};
        exp = {e.is_lsu, ~e.is_lsu, e.pc, e.rd, e.rs1, e.rs2, e.imm, e.use_imm,
               e.alu_op, e.is_store};
        if (got !== exp) begin
          errors++;
          $display("FAIL fire_uop pc=0x%08h: got 0x%022h expected 0x%022h", e.pc, got, exp);
        end else begin
          $display("ok   fire_uop pc=0x%08h instr=0x%08h", e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mkv(32'hFFB00093, 32'h1000, 1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFB, 1'b1, 4'h0, 1'b0);
    vecs[1] = mkv(32'h0021A423, 32'h1004, 1'b1, 5'd0,  5'd3,  5'd2,  32'h00000008, 1'b1, 4'h0, 1'b1);
    vecs[2] = mkv(32'h407302B3, 32'h1008, 1'b0, 5'd5,  5'd6,  5'd7,  32'h00000000, 1'b0, 4'h8, 1'b0);
    vecs[3] = mkv(32'h12345237, 32'h100C, 1'b0, 5'd4,  5'd0,  5'd0,  32'h12345000, 1'b1, 4'h0, 1'b0);
    vecs[4] = mkv(32'hFFC5A503, 32'h1010, 1'b1, 5'd10, 5'd11, 5'd0,  32'hFFFFFFFC, 1'b1, 4'h0, 1'b0);
    vecs[5] = mkv(32'h00A4F433, 32'h1014, 1'b0, 5'd8,  5'd9,  5'd10, 32'h00000000, 1'b0, 4'h7, 1'b0);
    vecs[6] = mkv(32'h4021D193, 32'h1018, 1'b0, 5'd3,  5'd3,  5'd0,  32'h00000402, 1'b1, 4'h5, 1'b0);
    vecs[7] = mkv(32'hFFF02FA3, 32'h101C, 1'b1, 5'd0,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b1, 4'h0, 1'b1);

    // Reset state
    repeat (3) tick();
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_lsu_valid", lsu_valid, 0);
    check("rst_illegal", illegal_instr, 0);
    check("rst_uop_imm", uop_imm, 0);
    rst_n = 1'b1;
    tick();

    // ADDI latency: pushed at edge N, visible after N+1
    push_v(vecs[0], 1'b1);
    check("addi_count_after_push", fifo_count, 1);
    check("addi_not_yet_valid", alu_valid, 0);
    tick();
    check("addi_alu_valid", alu_valid, 1);
    check("addi_rd", uop_rd, 1);
    check("addi_rs1", uop_rs1, 0);
    check("addi_imm", uop_imm, 32'hFFFFFFFB);
    check("addi_use_imm", uop_use_imm, 1);
    check("addi_alu_op", uop_alu_op, 0);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    check("addi_slot_cleared", alu_valid, 0);

    // SW held while LSU stalls
    push_v(vecs[1], 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("sw_stall_lsu_valid", lsu_valid, 1);
      check("sw_stall_alu_valid", alu_valid, 0);
      check("sw_stall_imm", uop_imm, 8);
      check("sw_stall_rd", uop_rd, 0);
      check("sw_stall_rs2", uop_rs2, 2);
      check("sw_stall_is_store", uop_is_store, 1);
      tick();
    end
    lsu_ready = 1'b1;
    tick();
    lsu_ready = 1'b0;
    check("sw_slot_cleared", lsu_valid, 0);

    // Fill slot + FIFO, full-cycle push rejected, then drain with pointer wrap
    for (int k = 1; k <= 5; k++) push_v(mk_addi(k, 32'h2000 + 32'(4 * k)), 1'b1);
    check("full_fetch_ready", fetch_ready, 0);
    check("full_count", fifo_count, 4);
    fetch_valid = 1'b1;
    fetch_instr = mk_addi(6, 32'h2018).instr;
    fetch_pc    = 32'h2018;
    tick();
    fetch_valid = 1'b0;
    check("full_push_rejected", fifo_count, 4);
    alu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", fifo_count, 32'(3 - i));
    end
    tick();
    alu_ready = 1'b0;
    check("drain_slot_empty", alu_valid, 0);
    check("drain_sb_empty", sb.size(), 0);

    // Illegal head dropped with one-cycle pulse, then SUB dispatches
    alu_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = 32'hFFFFFFFF;
    fetch_pc    = 32'h3000;
    tick();
    push_v(vecs[2], 1'b1);
    check("illegal_pulse", illegal_instr, 1);
    check("illegal_no_valid", alu_valid, 0);
    tick();
    check("illegal_pulse_end", illegal_instr, 0);
    check("sub_alu_valid", alu_valid, 1);
    check("sub_alu_op", uop_alu_op, 4'h8);
    check("sub_rs1", uop_rs1, 6);
    check("sub_rs2", uop_rs2, 7);
    check("sub_use_imm", uop_use_imm, 0);
    tick();
    alu_ready = 1'b0;
    check("sub_fired", alu_valid, 0);

    // Flush with full FIFO, valid slot, coincident push and fire
    for (int k = 1; k <= 5; k++) push_v(mk_addi(k + 10, 32'h4000 + 32'(4 * k)), 1'b0);
    check("preflush_count", fifo_count, 4);
    check("preflush_valid", alu_valid, 1);
    flush = 1'b1;
    alu_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_instr = vecs[4].instr;
    fetch_pc = 32'h4100;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    check("flush_count", fifo_count, 0);
    check("flush_alu_valid", alu_valid, 0);
    check("flush_lsu_valid", lsu_valid, 0);
    check("flush_fetch_ready", fetch_ready, 1);
    tick();
    tick();
    check("flush_push_dropped_alu", alu_valid, 0);
    check("flush_push_dropped_lsu", lsu_valid, 0);
    check("flush_count_stays", fifo_count, 0);
    alu_ready = 1'b0;

    // LUI stalled, then asynchronous reset mid-cycle
    push_v(vecs[3], 1'b0);
    tick();
    check("lui_valid", alu_valid, 1);
    check("lui_imm", uop_imm, 32'h12345000);
    check("lui_rd", uop_rd, 4);
    check("lui_rs1", uop_rs1, 0);
    check("lui_rs2", uop_rs2, 0);
    push_v(mk_addi(20, 32'h5000), 1'b0);
    push_v(mk_addi(21, 32'h5004), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_alu_valid", alu_valid, 0);
    check("arst_lsu_valid", lsu_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_fetch_ready", fetch_ready, 1);
    check("arst_uop_imm", uop_imm, 0);
    check("arst_uop_pc", uop_pc, 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_alu_valid", alu_valid, 0);

    // Decode table streamed back-to-back with both RS ready
    alu_ready = 1'b1;
    lsu_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_v(vecs[i], 1'b1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("table_drained", sb.size(), 0);
    tick();
    check("table_slot_empty", alu_valid | lsu_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
